// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the hazard / forwarding controller:
//     FWD_REG / FWD_WB / FWD_MEM : EX operand mux select codes
//     regnum_t                   : register-number field, wide enough for any
//                                  RBITS up to RN_MAX (narrower numbers are
//                                  zero-extended on entry)
//     slot_t / BUBBLE            : pipeline slot record and its empty value
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int unsigned RN_MAX = 7;

    typedef logic [RN_MAX:0] regnum_t;
    typedef logic [1:0]      fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    typedef struct packed {
        logic    Valid;
        regnum_t Rs;
        regnum_t Rt;
        regnum_t Rd;
        logic    RegWrite;
        logic    MemRead;
    } slot_t;

    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// ----------------------------------------------------------------------------
// fwd_select
//   Chooses the forwarding source for one EX operand.
//     src_i : register number read by the EX instruction for this operand
//     mem_i : MEM slot
//     wb_i  : WB slot
//     sel_o : FWD_MEM, FWD_WB or FWD_REG (never 2'b11)
//   A load in MEM has no data yet, so it is not a MEM source; its value is
//   picked up from WB one cycle later. Register 0 is never a source.
// ----------------------------------------------------------------------------
module fwd_select
    import hazard_pkg::*;
(
    input  regnum_t  src_i,
    input  slot_t    mem_i,
    input  slot_t    wb_i,
    output fwd_sel_t sel_o
);

    logic mem_hit;
    logic wb_hit;

    // Slot fields that play no part in source selection.
    logic unused_fields;
    assign unused_fields = ^{mem_i.Rs, mem_i.Rt, wb_i.Rs, wb_i.Rt, wb_i.MemRead};

    always_comb begin
        mem_hit = mem_i.Valid && mem_i.RegWrite && !mem_i.MemRead &&
                  (mem_i.Rd != '0) && (mem_i.Rd == src_i);
        wb_hit  = wb_i.Valid && wb_i.RegWrite &&
                  (wb_i.Rd != '0) && (wb_i.Rd == src_i);

        sel_o = FWD_REG;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_forward_ctrl
//   Tracks the instructions in EX/MEM/WB and produces the operand-forwarding
//   selects, the load-use stall and the taken-branch flush for a 5-stage pipe.
//   Ports:
//     Clock, Reset            : clock, asynchronous active-high reset
//     ID_Valid                : ID holds a real instruction
//     ID_Rs, ID_Rt, ID_Rd     : ID source / destination registers
//     ID_RegWrite, ID_MemRead : ID instruction writes a register / is a load
//     EX_BranchTaken          : branch or jump in EX resolved taken
//     FwdA, FwdB              : EX operand A/B mux selects
//     Stall                   : hold PC and IF/ID this cycle
//     Flush                   : clear IF/ID this cycle
//     StallCount              : saturating count of stall cycles
//   RBITS may not exceed hazard_pkg::RN_MAX.
// ----------------------------------------------------------------------------
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int RBITS = 4,
    parameter int CBITS = 15
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ID_Valid,
    input  logic [RBITS:0]   ID_Rs,
    input  logic [RBITS:0]   ID_Rt,
    input  logic [RBITS:0]   ID_Rd,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             EX_BranchTaken,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             Stall,
    output logic             Flush,
    output logic [CBITS:0]   StallCount
);

    slot_t          ex_q, mem_q, wb_q;
    slot_t          ex_d;
    logic [CBITS:0] cnt_q, cnt_d;
    regnum_t        id_rs, id_rt, id_rd;
    logic           stall_w;
    logic           flush_w;

    assign id_rs = regnum_t'(ID_Rs);
    assign id_rt = regnum_t'(ID_Rt);
    assign id_rd = regnum_t'(ID_Rd);

    // A taken branch masks the load-use stall, so the two never coincide.
    always_comb begin
        flush_w = EX_BranchTaken;
        stall_w = ID_Valid && ex_q.Valid && ex_q.MemRead && (ex_q.Rd != '0) &&
                  ((ex_q.Rd == id_rs) || (ex_q.Rd == id_rt)) && !flush_w;
    end

    always_comb begin
        ex_d = BUBBLE;
        if (ID_Valid && !flush_w && !stall_w) begin
            ex_d.Valid    = 1'b1;
            ex_d.Rs       = id_rs;
            ex_d.Rt       = id_rt;
            ex_d.Rd       = id_rd;
            ex_d.RegWrite = ID_RegWrite;
            ex_d.MemRead  = ID_MemRead;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_w && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .src_i (ex_q.Rs),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (FwdA)
    );

    fwd_select u_fwd_b (
        .src_i (ex_q.Rt),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (FwdB)
    );

    assign Stall      = stall_w;
    assign Flush      = flush_w;
    assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_forward_ctrl;

    localparam int TB_CBITS = 3;

    logic              Clock;
    logic              Reset;
    logic              ID_Valid;
    logic [4:0]        ID_Rs, ID_Rt, ID_Rd;
    logic              ID_RegWrite, ID_MemRead;
    logic              EX_BranchTaken;
    logic [1:0]        FwdA, FwdB;
    logic              Stall, Flush;
    logic [TB_CBITS:0] StallCount;

    typedef struct {
        logic [1:0]        fa;
        logic [1:0]        fb;
        logic              st;
        logic              fl;
        logic [TB_CBITS:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [TB_CBITS:0] exp_cnt;

    hazard_forward_ctrl #(.RBITS(4), .CBITS(TB_CBITS)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .ID_Valid       (ID_Valid),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_Rd          (ID_Rd),
        .ID_RegWrite    (ID_RegWrite),
        .ID_MemRead     (ID_MemRead),
        .EX_BranchTaken (EX_BranchTaken),
        .FwdA           (FwdA),
        .FwdB           (FwdB),
        .Stall          (Stall),
        .Flush          (Flush),
        .StallCount     (StallCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic drive(input logic v, input int rs, input int rt, input int rd,
                         input logic rw, input logic mr, input logic br);
        ID_Valid       = v;
        ID_Rs          = 5'(rs);
        ID_Rt          = 5'(rt);
        ID_Rd          = 5'(rd);
        ID_RegWrite    = rw;
        ID_MemRead     = mr;
        EX_BranchTaken = br;
    endtask

    task automatic push(input logic [1:0] fa, input logic [1:0] fb, input logic st,
                        input logic fl, input logic [TB_CBITS:0] cnt);
        exp_t e;
        e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard got empty want entry", tag);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checks++;
        assert (FwdA === e.fa) else begin
            errors++; $error("FAIL %s FwdA got %b want %b", tag, FwdA, e.fa);
        end
        checks++;
        assert (FwdB === e.fb) else begin
            errors++; $error("FAIL %s FwdB got %b want %b", tag, FwdB, e.fb);
        end
        checks++;
        assert (Stall === e.st) else begin
            errors++; $error("FAIL %s Stall got %b want %b", tag, Stall, e.st);
        end
        checks++;
        assert (Flush === e.fl) else begin
            errors++; $error("FAIL %s Flush got %b want %b", tag, Flush, e.fl);
        end
        checks++;
        assert (StallCount === e.cnt) else begin
            errors++; $error("FAIL %s StallCount got %0d want %0d", tag, StallCount, e.cnt);
        end
    endtask

    // Push the expectation for the current cycle, then sample mid-cycle.
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic st, input logic fl, input logic [TB_CBITS:0] cnt);
        push(fa, fb, st, fl, cnt);
        #3;
        check(tag);
    endtask

    task automatic next();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 Reset = 1'b1;
        #1;
        push(2'b00, 2'b00, 0, 0, 0); check("reset_idle");
        EX_BranchTaken = 1'b1;
        #1;
        push(2'b00, 2'b00, 0, 1, 0); check("reset_flush_follows");
        EX_BranchTaken = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b0;

        // back-to-back ALU: add $3 ; sub $9,$3,$4
        drive(1, 1, 2, 3, 1, 0, 0); step("s1_add",      2'b00, 2'b00, 0, 0, 0); next();
        drive(1, 3, 4, 9, 1, 0, 0); step("s2_sub",      2'b00, 2'b00, 0, 0, 0); next();
        // gap of one: writer $5, independent, reader of $5 as Rt
        drive(1, 1, 1, 5, 1, 0, 0); step("s3_b2b_mem",  2'b10, 2'b00, 0, 0, 0); next();
        drive(1, 2, 2, 6, 1, 0, 0); step("s4",          2'b00, 2'b00, 0, 0, 0); next();
        drive(1, 2, 5, 10, 1, 0, 0); step("s5",         2'b00, 2'b00, 0, 0, 0); next();
        // double match on $7
        drive(1, 1, 1, 7, 1, 0, 0); step("s6_gap_wb",   2'b00, 2'b01, 0, 0, 0); next();
        drive(1, 1, 1, 7, 1, 0, 0); step("s7",          2'b00, 2'b00, 0, 0, 0); next();
        drive(1, 7, 2, 11, 1, 0, 0); step("s8",         2'b00, 2'b00, 0, 0, 0); next();
        // load-use on $8
        drive(1, 1, 2, 8, 1, 1, 0); step("s9_double",   2'b10, 2'b00, 0, 0, 0); next();
        drive(1, 8, 3, 12, 1, 0, 0); step("s10_lu_stall", 2'b00, 2'b00, 1, 0, 0); next();
        step("s11_lu_bubble", 2'b00, 2'b00, 0, 0, 1); next();
        drive(0, 0, 0, 0, 0, 0, 0); step("s12_lu_wb",   2'b01, 2'b00, 0, 0, 1); next();
        // load-use masked by a taken branch
        drive(1, 1, 1, 9, 1, 1, 0); step("s13",         2'b00, 2'b00, 0, 0, 1); next();
        drive(1, 2, 9, 13, 1, 0, 1); step("s14_flush",  2'b00, 2'b00, 0, 1, 1); next();
        // register 0 is never a hazard or source
        drive(1, 13, 0, 0, 1, 1, 0); step("s15_ex_bub", 2'b00, 2'b00, 0, 0, 1); next();
        drive(1, 0, 0, 0, 1, 0, 0); step("s16_r0_stall", 2'b00, 2'b00, 0, 0, 1); next();
        drive(1, 0, 0, 15, 1, 0, 0); step("s17",        2'b00, 2'b00, 0, 0, 1); next();
        drive(1, 1, 1, 4, 1, 1, 0); step("s18_r0_fwd",  2'b00, 2'b00, 0, 0, 1); next();
        drive(1, 4, 0, 0, 0, 0, 0); step("s19_stall",   2'b00, 2'b00, 1, 0, 1);

        // asynchronous reset mid-stream with a stall pending
        #1 Reset = 1'b1;
        #1;
        push(2'b00, 2'b00, 0, 0, 0); check("async_reset");
        #1 Reset = 1'b0;
        drive(1, 1, 1, 2, 1, 0, 0);
        next();
        drive(1, 2, 2, 3, 1, 0, 0); step("s20_after_rst", 2'b00, 2'b00, 0, 0, 0); next();
        drive(0, 0, 0, 0, 0, 0, 0); step("s21_both_mem",  2'b10, 2'b10, 0, 0, 0); next();

        // repeated load-use stalls drive the counter into saturation
        exp_cnt = '0;
        for (int i = 0; i < 18; i++) begin
            drive(1, 1, 1, 8, 1, 1, 0);
            next();
            drive(1, 8, 1, 0, 0, 0, 0);
            step($sformatf("sat_stall_%0d", i), 2'b00, 2'b00, 1, 0, exp_cnt);
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            next();
            step($sformatf("sat_hold_%0d", i), 2'b00, 2'b00, 0, 0, exp_cnt);
            next();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL have parameter RBITS, default 4, MSB index of a register-number field (5-bit register numbers).
REQ-002 SHALL have parameter CBITS, default 15, MSB index of the stall counter.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port ID_Valid, input, 1, the ID stage holds a real instruction.
REQ-006 SHALL have ports ID_Rs and ID_Rt, input, RBITS+1 each, the source registers of the ID instruction.
REQ-007 SHALL have port ID_Rd, input, RBITS+1, the destination register of the ID instruction.
REQ-008 SHALL have ports ID_RegWrite and ID_MemRead, input, 1 each, the ID instruction writes a register or is a load.
REQ-009 SHALL have port EX_BranchTaken, input, 1, the branch or jump in EX resolved taken this cycle.
REQ-010 SHALL have ports FwdA and FwdB, output, 2 each, the EX operand A/B 3-way mux Control.
REQ-011 SHALL have port Stall, output, 1, hold the PC and IF/ID this cycle.
REQ-012 SHALL have port Flush, output, 1, clear IF/ID this cycle.
REQ-013 SHALL have port StallCount, output, CBITS+1, the saturating count of stall cycles.

Function
REQ-014 SHALL hold three internal slots, EX, MEM and WB, each {Valid, Rs, Rt, Rd, RegWrite, MemRead}; a bubble is all-zero.
REQ-015 SHALL, each cycle, shift WB<=MEM and MEM<=EX.
REQ-016 SHALL load EX with a bubble when Flush, Stall or !ID_Valid; otherwise EX<=ID fields.
REQ-017 SHALL drive FwdA as follows:
- 2'b10 (MEM) when MEM.RegWrite, !MEM.MemRead, MEM.Rd!=0 and MEM.Rd==EX.Rs;
- else 2'b01 (WB) when WB.RegWrite, WB.Rd!=0 and WB.Rd==EX.Rs;
- else 2'b00 (register file).
REQ-018 SHALL drive FwdB identically to FwdA, using EX.Rt.
REQ-019 SHALL give MEM priority over WB when both match; FwdA/FwdB never equals 2'b11.
REQ-020 SHALL make FwdA/FwdB combinational from slot state only, with zero latency after the edge.
REQ-021 SHALL assert Stall combinationally when:
- ID_Valid and EX.MemRead and EX.Rd!=0;
- and EX.Rd==ID_Rs or EX.Rd==ID_Rt;
- and !EX_BranchTaken.
REQ-022 SHALL make a load-use stall last exactly one cycle; the load then reaches MEM, and the consumer later receives FwdX=2'b01.
REQ-023 SHALL set Flush=EX_BranchTaken; Flush has priority over Stall, and both asserted is illegal.
REQ-024 SHALL leave MEM/WB slots unaffected by Flush; the taken branch in EX completes.
REQ-025 SHALL never treat register 0 as a hazard or forward source.
REQ-026 SHALL increment StallCount on each cycle Stall=1, saturating at all-ones.
REQ-027 SHALL allow simultaneous Stall and ID_Valid=0 only trivially; Stall requires ID_Valid.

Reset
REQ-028 SHALL, while Reset=1, immediately and asynchronously force all slots to bubble and StallCount to 0.
REQ-029 SHALL therefore give FwdA=FwdB=2'b00 during reset; Stall is 0 and Flush follows EX_BranchTaken.
REQ-030 SHALL discard any in-flight stall on reset mid-operation; the first edge after release loads EX normally.

Structure
REQ-031 SHALL put constants FWD_REG=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10 in a shared package hazard_pkg.
REQ-032 SHALL put the slot record layout and its BUBBLE constant in hazard_pkg.
REQ-033 SHALL implement the per-operand select in one sub-module, fwd_select, instantiated twice (Rs, Rt).

Verification
REQ-034 SHALL cover the ALU back-to-back case: add $3 then sub using $3 as Rs. The cycle sub is in EX, FwdA=2'b10 and FwdB=2'b00.
REQ-035 SHALL cover a gap of one: writer $5, an independent instruction, then a reader of $5 as Rt. The reader in EX sees FwdB=2'b01.
REQ-036 SHALL cover a double match: MEM and WB both write $7 and EX.Rs=7. The bench requires FwdA=2'b10.
REQ-037 SHALL cover load-use: lw $8 in EX with ID_Rs=8, giving Stall=1 for one cycle. EX then holds a bubble, the consumer later gets FwdA=2'b01, and StallCount increments by 1.
REQ-038 SHALL cover flush priority: a load-use condition plus EX_BranchTaken=1. Expect Flush=1, Stall=0 and EX bubble next cycle, with StallCount unchanged.
REQ-039 SHALL cover the $0 rule and reset: writer Rd=0 with reader Rs=0 gives FwdA=2'b00 and Stall=0. Asserting Reset mid-stream clears all outputs to 0 without a clock edge.
